keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Sits directly downstream of the Pmod keypad column scanner.
- Consumes the scanner's latched 4-bit key code and the raw keypad row lines.
- Debounces press/release per scan window and emits a one-cycle key event.
- Shifts accepted hex digits into a 4-digit entry register that drives the seven-segment display path.

Parameters:
- WINDOW_TICKS, 500000, clk ticks per presence window (5 ms at 100 MHz; longer than one full 4-column scan).
- DEBOUNCE_WINDOWS, 2, consecutive agreeing windows needed to confirm a press or a release (range 1..15).
- REPEAT_DELAY, 100, windows held before the first auto-repeat (only with the macro).
- REPEAT_PERIOD, 20, windows between subsequent auto-repeats (only with the macro).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous reset, active-low.
- key  in  4  latched key code from the scanner.
- row  in  4  keypad row lines, active-low; 4'hF means no key in the current column.
- clear  in  1  synchronous clear of the entry register.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_code  out  4  code of the last accepted key; valid on and after the key_valid cycle.
- value  out  16  entry register; newest digit in [3:0].
- digits  out  3  number of digits entered, saturates at 4.
- pressed  out  1  debounced key-down level.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0. window counter=0, seen_low=0, agree counter=0, FSM=IDLE.
  - Reset mid-window or mid-debounce discards all partial state.
- Window counter:
  - Counts 0..WINDOW_TICKS-1 and wraps.
  - seen_low is set in any cycle where row != 4'hF.
  - At the terminal tick, win_pressed = seen_low | (row != 4'hF). seen_low then clears for the next window.
- FSM, advanced only at terminal ticks:
  - IDLE: win_pressed increments agree, otherwise agree=0. When agree reaches DEBOUNCE_WINDOWS: go to HELD, agree=0, pressed=1, capture key into key_code, pulse key_valid next clk.
  - HELD: !win_pressed increments agree, otherwise agree=0. When agree reaches DEBOUNCE_WINDOWS: go to IDLE, pressed=0, no event.
- Latency:
  - key_valid asserts one clk after the terminal tick of the DEBOUNCE_WINDOWS-th consecutive pressed window.
  - key_valid is exactly 1 cycle wide.
- Entry register on key_valid:
  - value <= {value[11:0], key_code}.
  - digits <= min(digits+1, 4).
  - With digits already 4, the oldest digit falls off; there is no error flag.
- clear:
  - value=0, digits=0 on the next edge.
  - clear coincident with key_valid: clear wins for value/digits; key_valid still pulses and key_code still updates.
  - clear does not affect the FSM or the window counter.
- A new key pressed while HELD (no release in between) produces no event.
- The same key pressed twice with a confirmed release between produces two events.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD with continuous win_pressed, a repeat counter counts windows.
  - After REPEAT_DELAY windows: key_valid pulses with key_code re-sampled from key. Then it pulses every REPEAT_PERIOD windows.
  - The repeat counter resets on entering HELD and on any non-pressed window.
  - Repeats shift into value like normal events.
- Undefined: exactly one event per confirmed press; no repeat logic is synthesized.

Test Plan:
- Settings for all scenarios: WINDOW_TICKS=8, DEBOUNCE_WINDOWS=2; row/key change only at window boundaries unless stated.
- Reset: rst_n=0 for 3 clk with row=4'h0 -> all outputs 0. After release, no key_valid before 2 full windows.
- Single press: key=4'h5, row=4'hB for 3 windows, then 4'hF -> one key_valid pulse 1 clk after end of window 2. key_code=5, value=16'h0005, digits=1, pressed drops after 2 idle windows.
- Bounce: row low 1 window, high 1 window, low 1 window, high -> no key_valid, digits stays 0.
- Five entries 1,2,3,4,A, each with a confirmed release -> value=16'h234A, digits=4.
- clear coincident with the key_valid of key 7 (value previously 16'h0012) -> value=0, digits=0, key_valid=1, key_code=7.
- Macro defined, REPEAT_DELAY=3, REPEAT_PERIOD=2, key 9 held 9 windows -> key_valid at window 2, then after windows 5, 7 and 9. value=16'h9999.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: per-window debounce of the keypad scanner output and a 4-digit hex entry register.
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_entry #(
    parameter int WINDOW_TICKS     = 500000,
    parameter int DEBOUNCE_WINDOWS = 2,
    parameter int REPEAT_DELAY     = 100,
    parameter int REPEAT_PERIOD    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] value,
    output logic [2:0]  digits,
    output logic        pressed
);

    localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_TICKS - 1);
    localparam logic [3:0]       AGREE_LAST = 4'(DEBOUNCE_WINDOWS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Debounce state, kept as a named signal so checkers can bind to it.
    state_t state;

    logic [WIN_W-1:0] win_cnt;
    logic             seen_low;
    logic             row_low;
    logic             terminal;
    logic             win_pressed;
    logic [3:0]       agree;

    assign row_low     = (row != 4'hF);
    assign terminal    = (win_cnt == WIN_LAST);
    assign win_pressed = seen_low | row_low;

    // A window counts as pressed if any scan column reported a low row during it,
    // so one full column sweep must fit inside WINDOW_TICKS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            seen_low <= 1'b0;
        end else if (terminal) begin
            win_cnt  <= '0;
            seen_low <= 1'b0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (row_low) begin
                seen_low <= 1'b1;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic             rep_fire;

    // Before the first repeat the count runs to REPEAT_DELAY, afterwards to REPEAT_PERIOD.
    assign rep_fire = rep_armed ? (rep_cnt == REP_PERIOD_LAST) : (rep_cnt == REP_DELAY_LAST);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_PERIOD);
`endif

    // key_valid is a one-cycle strobe with no back-pressure: key_code is stable from
    // that cycle on, and the consumer must take the event in the cycle it is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            agree     <= 4'd0;
            pressed   <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (terminal) begin
                case (state)
                    IDLE: begin
                        if (win_pressed) begin
                            if (agree == AGREE_LAST) begin
                                state     <= HELD;
                                agree     <= 4'd0;
                                pressed   <= 1'b1;
                                key_code  <= key;
                                key_valid <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt   <= '0;
                                rep_armed <= 1'b0;
`endif
                            end else begin
                                agree <= agree + 4'd1;
                            end
                        end else begin
                            agree <= 4'd0;
                        end
                    end
                    HELD: begin
                        if (!win_pressed) begin
                            if (agree == AGREE_LAST) begin
                                state   <= IDLE;
                                agree   <= 4'd0;
                                pressed <= 1'b0;
                            end else begin
                                agree <= agree + 4'd1;
                            end
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
`endif
                        end else begin
                            agree <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rep_fire) begin
                                key_valid <= 1'b1;
                                key_code  <= key;
                                rep_cnt   <= '0;
                                rep_armed <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                        agree <= 4'd0;
                    end
                endcase
            end
        end
    end

    // clear takes priority over a coincident key event; the event itself is not suppressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value  <= 16'd0;
            digits <= 3'd0;
        end else if (clear) begin
            value  <= 16'd0;
            digits <= 3'd0;
        end else if (key_valid) begin
            value  <= {value[11:0], key_code};
            digits <= (digits == 3'd4) ? 3'd4 : digits + 3'd1;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: window-level stimulus with a queue-based reference model.
// Define KEYPAD_AUTOREPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_keypad_entry;

    localparam int WT = 8;
    localparam int DW = 2;
    localparam int RD = 3;
    localparam int RP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'd0;
    logic [3:0]  row = 4'hF;
    logic        clear = 1'b0;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic [2:0]  digits;
    logic        pressed;

    int errors = 0;
    int checks = 0;
    int ev_count = 0;
    logic obs_kv0 = 1'b0;

    // Reference model: window history, debounced level, held-window run, pending event, digit queue.
    bit         m_level;
    bit         hist[$];
    int         held_run;
    bit         pend_ev;
    logic [3:0] pend_kc;
    logic [3:0] last_kc;
    logic [3:0] dq[$];

    keypad_entry #(
        .WINDOW_TICKS(WT),
        .DEBOUNCE_WINDOWS(DW),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key(key),
        .row(row),
        .clear(clear),
        .key_valid(key_valid),
        .key_code(key_code),
        .value(value),
        .digits(digits),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_level  = 1'b0;
        hist.delete();
        held_run = 0;
        pend_ev  = 1'b0;
        pend_kc  = 4'd0;
        last_kc  = 4'd0;
        dq.delete();
    endtask

    task automatic apply_reset(input logic [3:0] r);
        rst_n = 1'b0;
        row   = r;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ev_count = 0;
    endtask

    // One presence window. mode 0: row held all window; 1: low only mid-window; 2: low only on the last tick.
    task automatic run_window(input logic [3:0] r, input logic [3:0] k, input int mode, input bit clr);
        logic        kv0;
        logic [3:0]  kc0;
        logic [15:0] v1;
        logic [2:0]  d1;
        logic        p1;
        int          extra;
        logic        exp_kv;
        logic [15:0] exp_value;
        logic [2:0]  exp_digits;
        logic        exp_pressed;
        bit          wp;
        bit          all_opp;
        bit          toggled;
        int          n;

        exp_kv = pend_ev;
        if (pend_ev) last_kc = pend_kc;
        if (clr) dq.delete();
        else if (pend_ev) begin
            dq.push_back(pend_kc);
            if (dq.size() > 4) void'(dq.pop_front());
        end
        exp_value = 16'd0;
        foreach (dq[j]) exp_value = {exp_value[11:0], dq[j]};
        exp_digits  = 3'(dq.size());
        exp_pressed = m_level;

        key   = k;
        clear = clr;
        extra = 0;
        kv0 = 1'b0; kc0 = 4'd0; v1 = 16'd0; d1 = 3'd0; p1 = 1'b0;
        for (int i = 0; i < WT; i++) begin
            if (mode == 0) row = r;
            else if ((mode == 1 && i == 3) || (mode == 2 && i == WT - 1)) row = r;
            else row = 4'hF;
            @(negedge clk);
            if (i == 0) begin
                kv0 = key_valid;
                kc0 = key_code;
            end else if (key_valid === 1'b1) begin
                extra++;
            end
            if (i == 1) begin
                v1 = value;
                d1 = digits;
                p1 = pressed;
            end
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
        obs_kv0 = kv0;
        if (kv0 === 1'b1) ev_count++;

        checks++;
        if (kv0 !== exp_kv) begin
            errors++;
            $display("FAIL key_valid_pulse: got %b expected %b", kv0, exp_kv);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL key_valid_width: got %0d extra high cycles expected 0", extra);
        end
        checks++;
        if (kc0 !== last_kc) begin
            errors++;
            $display("FAIL key_code: got %h expected %h", kc0, last_kc);
        end
        checks++;
        if (v1 !== exp_value) begin
            errors++;
            $display("FAIL value: got %h expected %h", v1, exp_value);
        end
        checks++;
        if (d1 !== exp_digits) begin
            errors++;
            $display("FAIL digits: got %0d expected %0d", d1, exp_digits);
        end
        checks++;
        if (p1 !== exp_pressed) begin
            errors++;
            $display("FAIL pressed: got %b expected %b", p1, exp_pressed);
        end

        // Advance the model: a level flips once the latest DW windows all disagree with it.
        wp = (r != 4'hF);
        pend_ev = 1'b0;
        toggled = 1'b0;
        hist.push_back(wp);
        n = hist.size();
        if (n >= DW) begin
            all_opp = 1'b1;
            for (int j = 0; j < DW; j++) if (hist[n-1-j] == m_level) all_opp = 1'b0;
            if (all_opp) begin
                m_level  = !m_level;
                toggled  = 1'b1;
                hist.delete();
                held_run = 0;
                if (m_level) begin
                    pend_ev = 1'b1;
                    pend_kc = k;
                end
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (!toggled && m_level) begin
            if (wp) begin
                held_run++;
                if (held_run == RD || (held_run > RD && (held_run - RD) % RP == 0)) begin
                    pend_ev = 1'b1;
                    pend_kc = k;
                end
            end else begin
                held_run = 0;
            end
        end
`endif
    endtask

    task automatic press_key(input logic [3:0] k);
        run_window(4'hE, k, 0, 1'b0);
        run_window(4'hE, k, 0, 1'b0);
        run_window(4'hF, k, 0, 1'b0);
        run_window(4'hF, k, 0, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset(4'h0);
        checks++;
        if ({key_valid, key_code, value, digits, pressed} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {key_valid, key_code, value, digits, pressed});
        end
        run_window(4'h0, 4'h3, 0, 1'b0);
        run_window(4'h0, 4'h3, 0, 1'b0);
        run_window(4'hF, 4'h3, 0, 1'b0);
        run_window(4'hF, 4'h3, 0, 1'b0);
        run_window(4'hF, 4'h3, 0, 1'b0);
        checks++;
        if (ev_count != 1) begin
            errors++;
            $display("FAIL reset_first_event: got %0d events expected 1", ev_count);
        end
    endtask

    task automatic test_reset_mid_debounce();
        apply_reset(4'hF);
        run_window(4'h7, 4'h8, 0, 1'b0);
        apply_reset(4'hF);
        run_window(4'h7, 4'h8, 0, 1'b0);
        run_window(4'hF, 4'h8, 0, 1'b0);
        run_window(4'hF, 4'h8, 0, 1'b0);
        checks++;
        if (ev_count != 0) begin
            errors++;
            $display("FAIL reset_discards_partial: got %0d events expected 0", ev_count);
        end
    endtask

    task automatic test_single_press();
        apply_reset(4'hF);
        for (int i = 0; i < 3; i++) run_window(4'hB, 4'h5, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_window(4'hF, 4'h5, 0, 1'b0);
        checks++;
        if (ev_count != 1 || value !== 16'h0005 || digits !== 3'd1 || key_code !== 4'h5 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL single_press: got ev=%0d value=%h digits=%0d code=%h pressed=%b expected ev=1 value=0005 digits=1 code=5 pressed=0",
                     ev_count, value, digits, key_code, pressed);
        end
    endtask

    task automatic test_bounce();
        apply_reset(4'hF);
        run_window(4'hD, 4'h1, 0, 1'b0);
        run_window(4'hF, 4'h1, 0, 1'b0);
        run_window(4'hD, 4'h1, 0, 1'b0);
        run_window(4'hF, 4'h1, 0, 1'b0);
        run_window(4'hF, 4'h1, 0, 1'b0);
        checks++;
        if (ev_count != 0 || digits !== 3'd0) begin
            errors++;
            $display("FAIL bounce: got ev=%0d digits=%0d expected ev=0 digits=0", ev_count, digits);
        end
    endtask

    task automatic test_five_entries();
        logic [3:0] keys[5];
        keys = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
        apply_reset(4'hF);
        foreach (keys[i]) press_key(keys[i]);
        checks++;
        if (value !== 16'h234A || digits !== 3'd4) begin
            errors++;
            $display("FAIL five_entries: got value=%h digits=%0d expected value=234a digits=4", value, digits);
        end
    endtask

    task automatic test_clear_with_event();
        apply_reset(4'hF);
        press_key(4'h1);
        press_key(4'h2);
        checks++;
        if (value !== 16'h0012) begin
            errors++;
            $display("FAIL clear_setup: got value=%h expected 0012", value);
        end
        run_window(4'hE, 4'h7, 0, 1'b0);
        run_window(4'hE, 4'h7, 0, 1'b0);
        run_window(4'hF, 4'h7, 0, 1'b1);
        checks++;
        if (obs_kv0 !== 1'b1 || key_code !== 4'h7 || value !== 16'h0000 || digits !== 3'd0) begin
            errors++;
            $display("FAIL clear_coincident: got kv=%b code=%h value=%h digits=%0d expected kv=1 code=7 value=0000 digits=0",
                     obs_kv0, key_code, value, digits);
        end
        run_window(4'hF, 4'h7, 0, 1'b0);
    endtask

    task automatic test_held_and_repress();
        apply_reset(4'hF);
        for (int i = 0; i < 3; i++) run_window(4'hB, 4'h5, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_window(4'h7, 4'h6, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_window(4'hF, 4'h6, 0, 1'b0);
        press_key(4'h5);
        press_key(4'h5);
        checks++;
        if (ev_count != 3 || value !== 16'h0555) begin
            errors++;
            $display("FAIL held_and_repress: got ev=%0d value=%h expected ev=3 value=0555", ev_count, value);
        end
    endtask

    task automatic test_presence_edges();
        apply_reset(4'hF);
        run_window(4'hE, 4'hC, 1, 1'b0);
        run_window(4'hE, 4'hC, 1, 1'b0);
        run_window(4'hF, 4'hC, 0, 1'b0);
        run_window(4'hF, 4'hC, 0, 1'b0);
        run_window(4'h7, 4'hD, 2, 1'b0);
        run_window(4'h7, 4'hD, 2, 1'b0);
        run_window(4'hF, 4'hD, 0, 1'b0);
        run_window(4'hF, 4'hD, 0, 1'b0);
        checks++;
        if (value !== 16'h00CD || digits !== 3'd2) begin
            errors++;
            $display("FAIL presence_edges: got value=%h digits=%0d expected value=00cd digits=2", value, digits);
        end
    endtask

    task automatic test_hold_long();
        apply_reset(4'hF);
        for (int i = 0; i < 9; i++) run_window(4'hB, 4'h9, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_window(4'hF, 4'h9, 0, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
        checks++;
        if (ev_count != 4 || value !== 16'h9999) begin
            errors++;
            $display("FAIL auto_repeat: got ev=%0d value=%h expected ev=4 value=9999", ev_count, value);
        end
`else
        checks++;
        if (ev_count != 1 || value !== 16'h0009) begin
            errors++;
            $display("FAIL no_repeat: got ev=%0d value=%h expected ev=1 value=0009", ev_count, value);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] k;
        apply_reset(4'hF);
        r = 4'hF;
        k = 4'd0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                r = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                k = 4'($urandom_range(0, 15));
            end
            run_window(r, k, (r == 4'hF) ? 0 : int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_debounce();
        test_single_press();
        test_bounce();
        test_five_entries();
        test_clear_with_event();
        test_held_and_repress();
        test_presence_edges();
        test_hold_long();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
